// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory stage with variable-latency req/ack data memory access
//
// Purpose: accepts one instruction at a time from execute, performs at most one
// data-memory access (load or store) over a req/ack handshake, stalls execute
// while the access is outstanding, and retires the instruction with a one-cycle
// done pulse. Unaligned/illegal accesses and ack timeouts park the stage in a
// sticky error state; HALT parks it in a sticky halted state.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   valid                       execute presents an instruction
//   aluOut, wrData              byte address and store data
//   memRead, memWrite, halt     instruction class
//   mem_req, mem_wr             memory request and direction (1=write)
//   mem_addr, mem_wdata         request address and store data
//   mem_ack, mem_rdata          memory completion and load data
//   rdData                      registered load data
//   done                        one-cycle retire pulse
//   stall                       upstream must hold its instruction
//   err, halted                 sticky status flags

module mem_access_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [15:0] aluOut,
    input  logic [15:0] wrData,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        halt,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] rdData,
    output logic        done,
    output logic        stall,
    output logic        err,
    output logic        halted
);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        DONE,
        HALTED,
        ERROR
    } state_t;

    state_t     state;
    logic [7:0] waitCnt;

    logic isMem;
    logic startAccess;
    logic badAccess;

    // Halt outranks any memory intent; read+write together is treated like
    // an unaligned access.
    assign isMem       = memRead | memWrite;
    assign badAccess   = valid & ~halt & isMem & ((memRead & memWrite) | aluOut[0]);
    assign startAccess = valid & ~halt & isMem & ~(memRead & memWrite) & ~aluOut[0];

    // Combinational so execute is held on the very cycle the access is
    // accepted; gated by rst_n so every output reads 0 while reset is held.
    assign stall = rst_n & ((state == ACCESS) | ((state == IDLE) & startAccess));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            waitCnt   <= 8'd0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 16'd0;
            mem_wdata <= 16'd0;
            rdData    <= 16'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            halted    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        if (halt) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                            done   <= 1'b1;
                        end else if (badAccess) begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end else if (startAccess) begin
                            state     <= ACCESS;
                            waitCnt   <= 8'd0;
                            mem_req   <= 1'b1;
                            mem_wr    <= memWrite;
                            mem_addr  <= aluOut;
                            mem_wdata <= wrData;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    // Ack is honoured before the timeout check, so an ack in
                    // the last allowed cycle still completes normally.
                    if (mem_ack) begin
                        if (!mem_wr) begin
                            rdData <= mem_rdata;
                        end
                        state     <= DONE;
                        done      <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_wr    <= 1'b0;
                        mem_addr  <= 16'd0;
                        mem_wdata <= 16'd0;
                    end else if (waitCnt == 8'(TIMEOUT - 1)) begin
                        state     <= ERROR;
                        err       <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_wr    <= 1'b0;
                        mem_addr  <= 16'd0;
                        mem_wdata <= 16'd0;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                HALTED: begin
                    state <= HALTED;
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
